// File: rtl/video_raw_to_rgb_seq_pkg.sv
// rtl/video_raw_to_rgb_seq_pkg.sv - shared types for the RAW-to-RGB parameter sequencer
package video_raw_to_rgb_seq_pkg;

    localparam int SEQ_ADDR_BITS = 40;
    localparam int SEQ_DATA_BITS = 32;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP,
        UPDATE
    } state_t;

    typedef struct packed {
        logic [SEQ_ADDR_BITS-1:0] addr;
        logic [SEQ_DATA_BITS-1:0] data;
    } entry_t;

endpackage

// File: rtl/video_raw_to_rgb_seq_table.sv
// rtl/video_raw_to_rgb_seq_table.sv - dual-port entry table, sync write, registered read
module video_raw_to_rgb_seq_table
    import video_raw_to_rgb_seq_pkg::*;
#(
    parameter int ENTRIES  = 16,
    parameter int IDX_BITS = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IDX_BITS-1:0] waddr,
    input  entry_t              wentry,
    input  logic                re,
    input  logic [IDX_BITS-1:0] raddr,
    output entry_t              rentry
);

    entry_t mem [ENTRIES];

    // Same-cycle write/read of one index returns the new entry, so a table
    // write coinciding with frame start is seen by the first beat.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wentry;
        end
        if (re) begin
            rentry <= (we && (waddr == raddr)) ? wentry : mem[raddr];
        end
    end

endmodule

// File: rtl/video_raw_to_rgb_param_sequencer.sv
// rtl/video_raw_to_rgb_param_sequencer.sv - frame-synchronous AXI4-Lite register table replay
module video_raw_to_rgb_param_sequencer
    import video_raw_to_rgb_seq_pkg::*;
#(
    parameter int ADDR_BITS = 40,
    parameter int DATA_BITS = 32,
    parameter int ENTRIES   = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         enable,
    input  logic                         frame_start,

    input  logic                         tbl_we,
    input  logic [$clog2(ENTRIES)-1:0]   tbl_addr,
    input  logic [ADDR_BITS-1:0]         tbl_waddr,
    input  logic [DATA_BITS-1:0]         tbl_wdata,
    input  logic [$clog2(ENTRIES):0]     tbl_count,
    output logic                         tbl_ack,

    output logic [ADDR_BITS-1:0]         m_axi4l_awaddr,
    output logic [2:0]                   m_axi4l_awprot,
    output logic                         m_axi4l_awvalid,
    input  logic                         m_axi4l_awready,
    output logic [DATA_BITS-1:0]         m_axi4l_wdata,
    output logic [DATA_BITS/8-1:0]       m_axi4l_wstrb,
    output logic                         m_axi4l_wvalid,
    input  logic                         m_axi4l_wready,
    input  logic [1:0]                   m_axi4l_bresp,
    input  logic                         m_axi4l_bvalid,
    output logic                         m_axi4l_bready,
    output logic [ADDR_BITS-1:0]         m_axi4l_araddr,
    output logic [2:0]                   m_axi4l_arprot,
    output logic                         m_axi4l_arvalid,
    output logic                         m_axi4l_rready,

    output logic                         update_req,
    output logic                         busy,
    output logic                         err_resp,
    output logic                         err_timeout,
    output logic                         err_overrun,
    input  logic                         err_clear
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int CNT_BITS = IDX_BITS + 1;
    localparam int TMR_BITS = $clog2(TIMEOUT + 1);

    state_t                state;
    state_t                state_next;
    logic [IDX_BITS-1:0]   index;
    logic [CNT_BITS-1:0]   count;
    logic [CNT_BITS-1:0]   count_clamped;
    logic [TMR_BITS-1:0]   timer;
    logic                  aw_done;
    logic                  w_done;

    logic                  aw_fire;
    logic                  w_fire;
    logic                  b_fire;
    logic                  last_entry;
    logic                  tmr_expired;
    logic                  timed_out;
    logic                  rd_en;
    logic [IDX_BITS-1:0]   rd_addr;

    entry_t                wr_entry;
    entry_t                rd_entry;

    assign tbl_ack = tbl_we & ~busy;

    assign wr_entry.addr = SEQ_ADDR_BITS'(tbl_waddr);
    assign wr_entry.data = SEQ_DATA_BITS'(tbl_wdata);

    video_raw_to_rgb_seq_table #(
        .ENTRIES (ENTRIES)
    ) u_table (
        .clk    (aclk),
        .we     (tbl_ack),
        .waddr  (tbl_addr),
        .wentry (wr_entry),
        .re     (rd_en),
        .raddr  (rd_addr),
        .rentry (rd_entry)
    );

    // An out-of-range count replays the whole table rather than wrapping forever.
    assign count_clamped = (tbl_count > CNT_BITS'(ENTRIES)) ? CNT_BITS'(ENTRIES) : tbl_count;

    assign aw_fire     = (state == ISSUE) && !aw_done && m_axi4l_awready;
    assign w_fire      = (state == ISSUE) && !w_done && m_axi4l_wready;
    assign b_fire      = (state == RESP) && m_axi4l_bvalid;
    assign last_entry  = ({1'b0, index} == (count - CNT_BITS'(1)));
    assign tmr_expired = (timer == TMR_BITS'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        rd_addr    = '0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start && enable) begin
                    if (tbl_count != '0) begin
                        state_next = ISSUE;
                        rd_en      = 1'b1;
                    end else begin
                        state_next = UPDATE;
                    end
                end
            end
            ISSUE: begin
                if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                    state_next = RESP;
                end else if (tmr_expired) begin
                    state_next = IDLE;
                    timed_out  = 1'b1;
                end
            end
            RESP: begin
                if (b_fire) begin
                    if (last_entry) begin
                        state_next = UPDATE;
                    end else begin
                        state_next = ISSUE;
                        rd_en      = 1'b1;
                        rd_addr    = index + IDX_BITS'(1);
                    end
                end else if (tmr_expired) begin
                    state_next = IDLE;
                    timed_out  = 1'b1;
                end
            end
            UPDATE: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            index       <= '0;
            count       <= '0;
            timer       <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            err_resp    <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state <= state_next;

            if (state == IDLE && state_next == ISSUE) begin
                index <= '0;
                count <= count_clamped;
            end else if (state == RESP && state_next == ISSUE) begin
                index <= index + IDX_BITS'(1);
            end

            // Each channel completes independently; both flags clear on every new beat.
            if (state_next == ISSUE && state != ISSUE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_fire) begin
                    aw_done <= 1'b1;
                end
                if (w_fire) begin
                    w_done <= 1'b1;
                end
            end

            if (state_next != state) begin
                timer <= '0;
            end else if (state == ISSUE || state == RESP) begin
                timer <= timer + TMR_BITS'(1);
            end

            if (err_clear) begin
                err_resp    <= 1'b0;
                err_timeout <= 1'b0;
                err_overrun <= 1'b0;
            end else begin
                if (b_fire && (m_axi4l_bresp != RESP_OKAY)) begin
                    err_resp <= 1'b1;
                end
                if (timed_out) begin
                    err_timeout <= 1'b1;
                end
                if (frame_start && state != IDLE) begin
                    err_overrun <= 1'b1;
                end
            end
        end
    end

    assign m_axi4l_awaddr  = rd_entry.addr[ADDR_BITS-1:0];
    assign m_axi4l_awprot  = 3'b000;
    assign m_axi4l_awvalid = (state == ISSUE) && !aw_done;
    assign m_axi4l_wdata   = rd_entry.data[DATA_BITS-1:0];
    assign m_axi4l_wstrb   = '1;
    assign m_axi4l_wvalid  = (state == ISSUE) && !w_done;
    assign m_axi4l_bready  = (state == RESP);
    assign m_axi4l_araddr  = '0;
    assign m_axi4l_arprot  = 3'b000;
    assign m_axi4l_arvalid = 1'b0;
    assign m_axi4l_rready  = 1'b0;

    assign update_req = (state == UPDATE);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_video_raw_to_rgb_param_sequencer.sv
// tb/tb_video_raw_to_rgb_param_sequencer.sv - randomized self-checking bench with reactive AXI4-Lite slave
module tb_video_raw_to_rgb_param_sequencer;

    localparam int AB = 40;
    localparam int DB = 32;
    localparam int EN = 16;
    localparam int TO = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          enable = 1'b0;
    logic          frame_start = 1'b0;
    logic          tbl_we = 1'b0;
    logic [3:0]    tbl_addr = '0;
    logic [AB-1:0] tbl_waddr = '0;
    logic [DB-1:0] tbl_wdata = '0;
    logic [4:0]    tbl_count = '0;
    logic          tbl_ack;
    logic [AB-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready = 1'b0;
    logic [DB-1:0] wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready = 1'b0;
    logic [1:0]    bresp = 2'b00;
    logic          bvalid = 1'b0;
    logic          bready;
    logic [AB-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          rready;
    logic          update_req;
    logic          busy;
    logic          err_resp;
    logic          err_timeout;
    logic          err_overrun;
    logic          err_clear = 1'b0;

    video_raw_to_rgb_param_sequencer #(
        .ADDR_BITS (AB),
        .DATA_BITS (DB),
        .ENTRIES   (EN),
        .TIMEOUT   (TO)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .enable          (enable),
        .frame_start     (frame_start),
        .tbl_we          (tbl_we),
        .tbl_addr        (tbl_addr),
        .tbl_waddr       (tbl_waddr),
        .tbl_wdata       (tbl_wdata),
        .tbl_count       (tbl_count),
        .tbl_ack         (tbl_ack),
        .m_axi4l_awaddr  (awaddr),
        .m_axi4l_awprot  (awprot),
        .m_axi4l_awvalid (awvalid),
        .m_axi4l_awready (awready),
        .m_axi4l_wdata   (wdata),
        .m_axi4l_wstrb   (wstrb),
        .m_axi4l_wvalid  (wvalid),
        .m_axi4l_wready  (wready),
        .m_axi4l_bresp   (bresp),
        .m_axi4l_bvalid  (bvalid),
        .m_axi4l_bready  (bready),
        .m_axi4l_araddr  (araddr),
        .m_axi4l_arprot  (arprot),
        .m_axi4l_arvalid (arvalid),
        .m_axi4l_rready  (rready),
        .update_req      (update_req),
        .busy            (busy),
        .err_resp        (err_resp),
        .err_timeout     (err_timeout),
        .err_overrun     (err_overrun),
        .err_clear       (err_clear)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference table contents as software believes they were loaded.
    logic [AB-1:0] m_addr [EN];
    logic [DB-1:0] m_data [EN];

    // Slave behaviour knobs and observed traffic.
    int            aw_lat = 0, w_lat = 0, b_lat = 0, err_idx = -1;
    bit            b_never = 1'b0;
    int            aw_cnt, w_cnt, b_cnt, b_n, aw_hi, w_hi, viol;
    bit            aw_wait, w_wait;
    logic [AB-1:0] aw_hold;
    logic [DB-1:0] w_hold;
    logic [AB-1:0] aw_q [$];
    logic [DB-1:0] w_q [$];

    task automatic reset_slave();
        aw_q.delete();
        w_q.delete();
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; b_n = 0;
        aw_hi = 0; w_hi = 0; viol = 0;
        aw_wait = 1'b0; w_wait = 1'b0;
    endtask

    always @(negedge aclk) begin
        int pairs;
        if (!aresetn) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        end else begin
            pairs = (aw_q.size() < w_q.size()) ? aw_q.size() : w_q.size();
            if (!b_never && b_n < pairs && b_cnt >= b_lat) begin
                bvalid = 1'b1;
                bresp  = (b_n == err_idx) ? 2'b10 : 2'b00;
                if (bready) begin
                    b_n++;
                    b_cnt = 0;
                end
            end else begin
                bvalid = 1'b0;
                bresp  = 2'b00;
                if (b_n < pairs) b_cnt++;
            end

            if (awvalid) begin
                aw_hi++;
                if ((aw_wait && awaddr !== aw_hold) || awprot !== 3'b000) viol++;
                if (aw_cnt >= aw_lat) begin
                    awready = 1'b1; aw_q.push_back(awaddr); aw_cnt = 0; aw_wait = 1'b0;
                end else begin
                    awready = 1'b0; aw_cnt++; aw_wait = 1'b1; aw_hold = awaddr;
                end
            end else begin
                awready = 1'b0;
                if (aw_wait) viol++;
                aw_wait = 1'b0;
            end

            if (wvalid) begin
                w_hi++;
                if ((w_wait && wdata !== w_hold) || wstrb !== 4'hf) viol++;
                if (w_cnt >= w_lat) begin
                    wready = 1'b1; w_q.push_back(wdata); w_cnt = 0; w_wait = 1'b0;
                end else begin
                    wready = 1'b0; w_cnt++; w_wait = 1'b1; w_hold = wdata;
                end
            end else begin
                wready = 1'b0;
                if (w_wait) viol++;
                w_wait = 1'b0;
            end

            if (arvalid || rready) viol++;
        end
    end

    task automatic load_entry(input int idx, input logic [AB-1:0] a, input logic [DB-1:0] d);
        @(negedge aclk);
        tbl_we = 1'b1; tbl_addr = idx[3:0]; tbl_waddr = a; tbl_wdata = d;
        #1;
        check("tbl_ack_idle", tbl_ack, 1'b1);
        m_addr[idx] = a;
        m_data[idx] = d;
        @(negedge aclk);
        tbl_we = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge aclk);
        err_clear = 1'b1;
        @(negedge aclk);
        err_clear = 1'b0;
    endtask

    // Cycle 0 is the edge that samples frame_start; t counts cycles after it.
    task automatic run_frame(input int n, input bit en, input int inj, input bit wr_same,
                             output int t_upd, output int n_upd, output int t_end);
        int t;
        reset_slave();
        @(negedge aclk);
        enable = en; tbl_count = n[4:0]; frame_start = 1'b1;
        if (wr_same) begin
            tbl_we = 1'b1; tbl_addr = 4'd0;
            tbl_waddr = {$urandom, $urandom}; tbl_wdata = $urandom;
            m_addr[0] = tbl_waddr; m_data[0] = tbl_wdata;
        end
        @(negedge aclk);
        frame_start = 1'b0; tbl_we = 1'b0;
        t = 1; t_upd = -1; n_upd = 0;
        forever begin
            if (update_req) begin
                n_upd++;
                if (t_upd < 0) t_upd = t;
            end
            if (t == inj) begin
                frame_start = 1'b1; tbl_we = 1'b1; tbl_addr = 4'(n - 1);
                tbl_waddr = {$urandom, $urandom}; tbl_wdata = $urandom;
                #1;
                check("tbl_ack_busy", tbl_ack, 1'b0);
            end else begin
                frame_start = 1'b0; tbl_we = 1'b0;
            end
            if (!busy) break;
            if (t >= 3000) begin
                check("seq_finish_bound", 1'b0, 1'b1);
                break;
            end
            @(negedge aclk);
            t++;
        end
        frame_start = 1'b0; tbl_we = 1'b0;
        t_end = t;
    endtask

    task automatic verify(input string tag, input int n, input int t_upd, input int n_upd, input int t_end);
        int per;
        per = ((aw_lat > w_lat) ? aw_lat : w_lat) + 1 + b_lat + 1;
        check({tag, "_aw_beats"}, aw_q.size(), n);
        check({tag, "_w_beats"}, w_q.size(), n);
        check({tag, "_b_beats"}, b_n, n);
        for (int i = 0; i < n && i < aw_q.size() && i < w_q.size(); i++) begin
            check($sformatf("%s_awaddr%0d", tag, i), aw_q[i], m_addr[i]);
            check($sformatf("%s_wdata%0d", tag, i), w_q[i], m_data[i]);
        end
        check({tag, "_upd_pulses"}, n_upd, 1);
        check({tag, "_upd_cycle"}, t_upd, 1 + n * per);
        check({tag, "_end_cycle"}, t_end, 2 + n * per);
        check({tag, "_aw_hi"}, aw_hi, n * (aw_lat + 1));
        check({tag, "_w_hi"}, w_hi, n * (w_lat + 1));
        check({tag, "_protocol"}, viol, 0);
        check({tag, "_err_resp"}, err_resp, (err_idx >= 0 && err_idx < n));
    endtask

    initial begin
        int tu, nu, te, n;
        reset_slave();
        repeat (3) @(negedge aclk);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_update", update_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_errs", {err_resp, err_timeout, err_overrun}, 3'b000);
        aresetn = 1'b1;

        load_entry(0, 40'ha0121000, 32'd1);
        load_entry(1, 40'ha0122000, 32'd2);
        load_entry(2, 40'ha0121010, 32'd3);
        run_frame(3, 1'b1, -1, 1'b0, tu, nu, te);
        verify("basic", 3, tu, nu, te);

        aw_lat = 4;
        run_frame(3, 1'b1, -1, 1'b0, tu, nu, te);
        verify("aw_slow", 3, tu, nu, te);
        aw_lat = 0;

        err_idx = 1;
        run_frame(3, 1'b1, -1, 1'b0, tu, nu, te);
        verify("bresp_err", 3, tu, nu, te);
        pulse_clear();
        check("err_resp_cleared", err_resp, 1'b0);
        err_idx = -1;

        b_never = 1'b1;
        run_frame(1, 1'b1, -1, 1'b0, tu, nu, te);
        check("tmo_upd_pulses", nu, 0);
        check("tmo_end_cycle", te, 2 + TO);
        check("tmo_flag", err_timeout, 1'b1);
        check("tmo_busy", busy, 1'b0);
        b_never = 1'b0;
        pulse_clear();
        check("tmo_cleared", err_timeout, 1'b0);

        run_frame(3, 1'b1, 3, 1'b0, tu, nu, te);
        verify("overrun", 3, tu, nu, te);
        check("overrun_flag", err_overrun, 1'b1);
        pulse_clear();

        run_frame(0, 1'b1, -1, 1'b0, tu, nu, te);
        verify("count0", 0, tu, nu, te);

        run_frame(3, 1'b0, -1, 1'b0, tu, nu, te);
        check("disabled_upd", nu, 0);
        check("disabled_end", te, 1);
        check("disabled_aw", aw_q.size(), 0);

        run_frame(2, 1'b1, -1, 1'b1, tu, nu, te);
        verify("same_cycle_wr", 2, tu, nu, te);

        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < EN; i++) load_entry(i, {$urandom, $urandom}, $urandom);
            n = $urandom_range(1, EN);
            aw_lat = $urandom_range(0, 3);
            w_lat = $urandom_range(0, 3);
            b_lat = $urandom_range(0, 3);
            err_idx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
            run_frame(n, 1'b1, -1, 1'b0, tu, nu, te);
            verify($sformatf("rand%0d", it), n, tu, nu, te);
            pulse_clear();
        end
        aw_lat = 10; w_lat = 0; b_lat = 0; err_idx = -1;

        reset_slave();
        @(negedge aclk);
        enable = 1'b1; tbl_count = 5'd2; frame_start = 1'b1;
        @(negedge aclk);
        frame_start = 1'b0;
        check("mid_rst_pre_awvalid", awvalid, 1'b1);
        check("mid_rst_pre_busy", busy, 1'b1);
        aresetn = 1'b0;
        #1;
        check("mid_rst_awvalid", awvalid, 1'b0);
        check("mid_rst_wvalid", wvalid, 1'b0);
        check("mid_rst_bready", bready, 1'b0);
        check("mid_rst_update", update_req, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_errs", {err_resp, err_timeout, err_overrun}, 3'b000);
        reset_slave();
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
